// File: rtl/image_cache_sequencer.sv
// Frame sequencer for the image_cache line buffer: clears the cache, streams one
// frame through a single output register, appends bottom pad rows and tags window centres.
module image_cache_sequencer #(
    parameter int IMAGE_COLUMN     = 512,
    parameter int IMAGE_ROW        = 512,
    parameter int IMAGE_DATA_WIDTH = 8,
    parameter int CONV_KERNEL_SIZE = 11,
    parameter int CACHE_RST_CYCLES = 16,
    parameter int SETTLE_CYCLES    = 16,
    parameter logic [IMAGE_DATA_WIDTH-1:0] PAD_VALUE = '0,
    localparam int H  = CONV_KERNEL_SIZE / 2,
    localparam int CW = $clog2(IMAGE_COLUMN),
    localparam int RW = $clog2(IMAGE_ROW + H)
) (
    input  logic                        axi_clk,
    input  logic                        axi_rst,
    input  logic                        frame_start,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        tlast_err,
    output logic                        cache_rst,
    input  logic [IMAGE_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [IMAGE_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic                        win_valid,
    output logic [RW-1:0]               win_row,
    output logic [CW-1:0]               win_col
);

    localparam int CNT_MAX = (CACHE_RST_CYCLES > SETTLE_CYCLES) ? CACHE_RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMAGE_COLUMN - 1);
    localparam logic [RW-1:0] ROW_LAST_REAL = RW'(IMAGE_ROW - 1);
    localparam logic [RW-1:0] ROW_LAST_PAD  = RW'(IMAGE_ROW + H - 1);
    localparam logic [RW-1:0] ROW_HALF      = RW'(H);
    localparam logic [CW-1:0] COL_HALF      = CW'(H);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CLEAR, ST_SETTLE, ST_STREAM, ST_FLUSH, ST_DONE
    } state_t;

    state_t                        state_reg;
    logic [CNT_W-1:0]              cnt_reg;
    logic [CW-1:0]                 col_reg;
    logic [RW-1:0]                 row_reg;
    logic                          last_loaded_reg;
    logic                          tlast_err_reg;
    logic                          m_valid_reg;
    logic [IMAGE_DATA_WIDTH-1:0]   m_data_reg;
    logic                          m_last_reg;
    logic                          win_valid_reg;
    logic [RW-1:0]                 win_row_reg;
    logic [CW-1:0]                 win_col_reg;

    logic reg_free;
    logic stream_load;
    logic flush_load;
    logic beat_load;
    logic col_wrap;
    logic window_full;

    // The output register may take a new beat when it is empty or being drained.
    assign reg_free    = !m_valid_reg || m_axis_tready;
    assign stream_load = (state_reg == ST_STREAM) && reg_free && s_axis_tvalid;
    assign flush_load  = (state_reg == ST_FLUSH) && reg_free && !last_loaded_reg;
    assign beat_load   = stream_load || flush_load;
    assign col_wrap    = (col_reg == COL_LAST);
    assign window_full = (int'(row_reg) >= CONV_KERNEL_SIZE - 1) &&
                         (int'(col_reg) >= CONV_KERNEL_SIZE - 1);

    assign busy          = (state_reg != ST_IDLE);
    assign frame_done    = (state_reg == ST_DONE);
    assign cache_rst     = (state_reg == ST_CLEAR);
    assign s_axis_tready = (state_reg == ST_STREAM) && reg_free;
    assign tlast_err     = tlast_err_reg;
    assign m_axis_tvalid = m_valid_reg;
    assign m_axis_tdata  = m_data_reg;
    assign m_axis_tlast  = m_last_reg;
    assign win_valid     = win_valid_reg;
    assign win_row       = win_row_reg;
    assign win_col       = win_col_reg;

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            last_loaded_reg <= 1'b0;
            tlast_err_reg   <= 1'b0;
            m_valid_reg     <= 1'b0;
            m_data_reg      <= '0;
            m_last_reg      <= 1'b0;
            win_valid_reg   <= 1'b0;
            win_row_reg     <= '0;
            win_col_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (frame_start) begin
                        state_reg <= ST_CLEAR;
                        cnt_reg   <= '0;
                    end
                end
                ST_CLEAR: begin
                    col_reg         <= '0;
                    row_reg         <= '0;
                    last_loaded_reg <= 1'b0;
                    tlast_err_reg   <= 1'b0;
                    if (cnt_reg == CNT_W'(CACHE_RST_CYCLES - 1)) begin
                        state_reg <= ST_SETTLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_reg <= ST_STREAM;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (stream_load && (row_reg == ROW_LAST_REAL) && col_wrap) begin
                        state_reg <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Done only once the final pad beat has left the register.
                    if (m_valid_reg && m_axis_tready && last_loaded_reg) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (beat_load) begin
                m_valid_reg   <= 1'b1;
                m_data_reg    <= stream_load ? s_axis_tdata : PAD_VALUE;
                m_last_reg    <= col_wrap;
                win_valid_reg <= window_full;
                win_row_reg   <= window_full ? (row_reg - ROW_HALF) : '0;
                win_col_reg   <= window_full ? (col_reg - COL_HALF) : '0;
                if (col_wrap) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
                if (flush_load && (row_reg == ROW_LAST_PAD) && col_wrap) begin
                    last_loaded_reg <= 1'b1;
                end
            end else if (m_axis_tready) begin
                m_valid_reg   <= 1'b0;
                win_valid_reg <= 1'b0;
                win_row_reg   <= '0;
                win_col_reg   <= '0;
            end

            if (stream_load && (s_axis_tlast != col_wrap)) begin
                tlast_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: doc/image_cache_sequencer.md
# image_cache_sequencer

Frame-level controller that sits in front of the `image_cache` line buffer and sequences one image frame through it. It performs four jobs:
- clears the cache FIFOs before each frame;
- gates upstream pixels into the cache, regenerating per-row `tlast`;
- appends bottom-border pad rows so the last real rows drain through the kernel window;
- tags every cache-bound beat with the window-centre coordinates and a window-valid qualifier for the downstream convolution.

## Interface
Parameters:
- IMAGE_COLUMN, 512: pixels per row (m).
- IMAGE_ROW, 512: real rows per frame.
- IMAGE_DATA_WIDTH, 8: pixel width.
- CONV_KERNEL_SIZE, 11: kernel size K. K must be odd and ≥3. H = K/2 (integer division).
- CACHE_RST_CYCLES, 16: cycles `cache_rst` is held high. Must be ≥1 and ≥100 ns at the clock rate.
- SETTLE_CYCLES, 16: idle cycles after `cache_rst` falls before the first pixel is accepted. Must be ≥1.
- PAD_VALUE, 0: pixel value injected in pad rows.

Ports (CW = clog2(IMAGE_COLUMN), RW = clog2(IMAGE_ROW+H)):
- axi_clk, in, 1: single clock.
- axi_rst, in, 1: synchronous, active-high reset.
- frame_start, in, 1: request to run one frame. Sampled only in IDLE.
- busy, out, 1: high in every state except IDLE.
- frame_done, out, 1: one-cycle pulse at frame completion.
- tlast_err, out, 1: sticky upstream `tlast` misalignment flag.
- cache_rst, out, 1: reset to the cache FIFOs. The integrator ORs it with `axi_rst`.
- s_axis_tdata / s_axis_tvalid / s_axis_tlast, in, IMAGE_DATA_WIDTH / 1 / 1: upstream pixels.
- s_axis_tready, out, 1: upstream ready.
- m_axis_tdata / m_axis_tvalid / m_axis_tlast, out, IMAGE_DATA_WIDTH / 1 / 1: beats to the cache.
- m_axis_tready, in, 1: cache ready.
- win_valid, out, 1: the current m beat completes a full K×K window.
- win_row / win_col, out, RW / CW: window-centre coordinates of the current m beat.

## Operation
- States:
  - IDLE: on `frame_start`, go to CLEAR. All other inputs are ignored.
  - CLEAR: hold `cache_rst` high for CACHE_RST_CYCLES, then go to SETTLE. Zero the row/col counters and clear `tlast_err`.
  - SETTLE: count SETTLE_CYCLES, then go to STREAM.
  - STREAM: accept upstream beats. After the beat at (row IMAGE_ROW-1, col IMAGE_COLUMN-1) is accepted, go to FLUSH.
  - FLUSH: emit H×IMAGE_COLUMN beats of PAD_VALUE. After the last pad beat is handshaken on m, go to DONE.
  - DONE: pulse `frame_done` for one cycle, then go to IDLE.
- Output register: one m-side output register. A beat loads it when the register is empty or `m_axis_tready` is high.
  - In STREAM, `s_axis_tready` = (register empty or `m_axis_tready`). It is 0 in every other state.
  - In FLUSH the register reloads with pad beats under the same rule.
- Counters: col runs 0..IMAGE_COLUMN-1 and wraps. row increments on the col wrap and runs 0..IMAGE_ROW+H-1 across STREAM and FLUSH. Counters advance only on beats loaded into the register.
- `m_axis_tlast` = 1 on beats with col = IMAGE_COLUMN-1. Upstream `s_axis_tlast` is not forwarded.
- `tlast_err`: set when an accepted upstream beat has `s_axis_tlast` ≠ (col = IMAGE_COLUMN-1). The beat is still forwarded and the frame continues. The flag clears only in CLEAR or on reset.
- Window tagging, per beat (r, c) in the register:
  - `win_valid` = `m_axis_tvalid` and r ≥ K-1 and c ≥ K-1.
  - `win_row` = r-H and `win_col` = c-H when `win_valid` = 1; both are 0 otherwise.
- Beat totals per frame: upstream accepted = IMAGE_COLUMN×IMAGE_ROW; m beats = IMAGE_COLUMN×(IMAGE_ROW+H).
- `axi_rst` at any time, including mid-frame: next state IDLE and the register is emptied. The FIFOs are cleared by the integrator's OR of `axi_rst` into `cache_rst`.

## Timing
- Reset values: `busy`, `frame_done`, `tlast_err`, `cache_rst`, `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, `win_valid` = 0. `m_axis_tdata`, `win_row`, `win_col` = 0.
- Cycle numbering (`frame_start` sampled in cycle 0):
  - `busy` rises in cycle 1.
  - `cache_rst` is high in cycles 1..CACHE_RST_CYCLES.
  - SETTLE occupies the next SETTLE_CYCLES cycles.
  - `s_axis_tready` first rises in cycle CACHE_RST_CYCLES+SETTLE_CYCLES+1.
- Latency: an upstream beat accepted in cycle t appears on m in cycle t+1.
- The `win_*` outputs are valid in the same cycle as their m beat.
- `frame_done` is asserted in the cycle after the last pad handshake. `busy` falls in the cycle after `frame_done`.
- Zero-bubble throughput: with `m_axis_tready` = 1 and `s_axis_tvalid` = 1, one beat per cycle, including across the STREAM→FLUSH boundary.
- Holding rules:
  - `m_axis_tdata`, `m_axis_tlast` and the `win_*` outputs hold stable while `m_axis_tvalid` = 1 and `m_axis_tready` = 0.
  - `m_axis_tvalid` never drops without a handshake.

## Test plan
Bench parameters: IMAGE_COLUMN=16, IMAGE_ROW=8, K=3 (H=1), CACHE_RST_CYCLES=4, SETTLE_CYCLES=2.
- Reset check: after `axi_rst`, all outputs are 0; a `frame_start` one cycle after reset release gives `busy`=1 in cycle 1.
- Full frame, `s_axis_tvalid`=1, `m_axis_tready`=1, correct `tlast`:
  - `cache_rst` is high in cycles 1–4 and `s_axis_tready` rises in cycle 7.
  - 128 beats accepted, 144 m beats, the last 16 equal to PAD_VALUE.
  - `m_axis_tlast` on every 16th beat.
  - 98 `win_valid` beats, the first with (`win_row`,`win_col`)=(1,1) and the last with (7,14).
  - Exactly one `frame_done`; `tlast_err`=0.
- Random `m_axis_tready` (≈50%) and `s_axis_tvalid` gaps:
  - The m data sequence equals the input sequence followed by 16 pads, with no loss or duplication.
  - Data and `win_*` are stable while stalled.
- Wrong upstream `tlast` (at row 0, col 5, and missing at row 0, col 15):
  - `tlast_err` = 1 from the cycle after the first error and stays 1.
  - The frame still completes with 144 m beats.
  - `tlast_err` clears in the next frame's CLEAR.
- `frame_start` pulses during STREAM are ignored: no restart and beat totals unchanged.
- Mid-frame reset: `axi_rst` after 40 accepted beats returns the block to IDLE with all outputs at reset values; a following `frame_start` runs a clean 144-beat frame.
